// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and the receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // 25 MHz / 115200 baud
  localparam int UART_CLKS_PER_BIT = 217;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side bus of the UART transmitter: write strobe/data, serial line, status word.
interface uart_tx_if;
  logic        load;
  logic [15:0] in;
  logic        tx;
  logic [15:0] out;

  modport master (output load, output in, input tx, input out);
  modport slave  (input load, input in, output tx, output out);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the shifter; pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] data_in,
  input  logic       pop,
  output logic [7:0] data_out,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Fullness/emptiness come from the registered count, so a same-cycle pop never makes room
  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign data_out = r_mem[r_head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= data_in;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write FIFO and a memory-mapped status word.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DEPTH        = 4
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t r_state;
  uart_tx_state_t w_state_nxt;
  logic [BW-1:0]  r_baud;
  logic [BW-1:0]  w_baud_nxt;
  logic [2:0]     r_bit_idx;
  logic [2:0]     w_bit_nxt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nxt;
  logic           r_tx;
  logic           w_tx_nxt;
  logic           w_pop;
  logic           w_bit_end;
  logic [7:0]     w_fifo_data;
  logic           w_full;
  logic           w_empty;
  logic           w_unused_hi;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.load),
    .data_in  (bus.in[7:0]),
    .pop      (w_pop),
    .data_out (w_fifo_data),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign w_unused_hi = ^bus.in[15:8];
  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign bus.tx      = r_tx;
  assign bus.out     = {w_full, (!w_empty || (r_state != IDLE)), 14'd0};

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_bit_nxt   = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit_idx + 1'b1;
          if (r_bit_idx == LAST_BIT) w_state_nxt = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_bit_nxt   = '0;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level is computed for the next state so tx itself stays a plain flop
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a timeline model predicts acceptance, frame start edges and status.
module tb_uart_tx;

  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         st;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   edge_n = 0;
  int   total = 0;
  int   bad = 0;
  rec_t recs[$];
  rec_t exp_q[$];
  logic [7:0] rx_byte;

  uart_tx_if u_if ();

  uart_tx #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edge_n);
    end
  endtask

  // Byte accepted iff fewer than D bytes wait before the edge; it starts one edge later,
  // or right when the previous frame's stop bit ends, whichever is later.
  task automatic model_push(input logic [7:0] d);
    int   n;
    int   occ;
    rec_t r;
    n   = edge_n + 1;
    occ = 0;
    foreach (recs[i]) if (recs[i].acc < n && recs[i].st >= n) occ++;
    if (occ < D) begin
      r.data = d;
      r.acc  = n;
      r.st   = n + 1;
      if (recs.size() > 0 && recs[$].st + FRAME > r.st) r.st = recs[$].st + FRAME;
      recs.push_back(r);
      exp_q.push_back(r);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    u_if.load = 1'b1;
    u_if.in   = v;
    model_push(v[7:0]);
    @(negedge clk);
    u_if.load = 1'b0;
  endtask

  // Monitor: status word and serial line against the model, sampled on the falling edge
  always @(negedge clk) begin
    int busy;
    int occ;
    int off;
    int k;
    int expbit;
    if (!reset) begin
      chk("tx_in_reset", 32'(u_if.tx), 32'd1);
      chk("out_in_reset", 32'(u_if.out), 32'd0);
    end else begin
      busy = 0;
      occ  = 0;
      foreach (recs[i]) begin
        if (recs[i].acc <= edge_n && recs[i].st + FRAME > edge_n) busy = 1;
        if (recs[i].acc <= edge_n && recs[i].st > edge_n) occ++;
      end
      chk("out_busy", 32'(u_if.out[14]), 32'(busy));
      chk("out_full", 32'(u_if.out[15]), 32'(occ == D));
      chk("out_zero", 32'(u_if.out[13:0]), 32'd0);
      if (exp_q.size() > 0 && edge_n >= exp_q[0].st) begin
        off = edge_n - exp_q[0].st;
        k   = off / C;
        if (k == 0)      expbit = 0;
        else if (k == 9) expbit = 1;
        else             expbit = 32'(exp_q[0].data[k-1]);
        chk("tx_bit", 32'(u_if.tx), 32'(expbit));
        if ((off % C) == C / 2 && k >= 1 && k <= 8) rx_byte[k-1] = u_if.tx;
        if (off == FRAME - 1) begin
          chk("frame_byte", 32'(rx_byte), 32'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
      end else begin
        chk("tx_idle", 32'(u_if.tx), 32'd1);
      end
    end
  end

  initial begin
    int p;
    int st;
    u_if.load = 1'b0;
    u_if.in   = 16'h0000;
    rx_byte   = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(u_if.tx), 32'd1);
    chk("reset_out", 32'(u_if.out), 32'd0);
    reset = 1'b1;
    repeat (50) @(negedge clk);

    do_load(16'h00A5);
    repeat (50) @(negedge clk);

    do_load(16'hFF3C);
    repeat (50) @(negedge clk);

    // Overflow burst, then a push landing exactly on a STOP pop while full
    for (int i = 1; i <= 6; i++) do_load(16'(i));
    p = 0;
    foreach (recs[i]) if (recs[i].st > edge_n + 1 && (p == 0 || recs[i].st < p)) p = recs[i].st;
    while (edge_n + 1 < p) @(negedge clk);
    do_load(16'h0077);
    do_load(16'h0088);
    repeat ((D + 2) * FRAME) @(negedge clk);

    // Reset during data bit 3 of 8'hFF
    do_load(16'h00FF);
    st = recs[$].st;
    while (edge_n < st + 4 * C + 1) @(negedge clk);
    chk("tx_bit3_high", 32'(u_if.tx), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("tx_async_reset", 32'(u_if.tx), 32'd1);
    chk("out_async_reset", 32'(u_if.out), 32'd0);
    recs.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 8 : 40)) do_load(16'($urandom));
      else @(negedge clk);
    end
    repeat ((D + 2) * FRAME) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
